// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter, per-channel duty
// compare and polarity, with period/duty/mode shadow registers transferred at the period boundary.
module pwm_multi_channel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [WIDTH-1:0]          period_in,
  input  logic                      period_we,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       duty_we,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      update_pending
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          cnt_r;
  logic                      dir_down_r;
  logic [WIDTH-1:0]          act_period_r;
  logic [WIDTH-1:0]          sh_period_r;
  logic                      act_center_r;
  logic                      sh_center_r;
  logic [CHANNELS*WIDTH-1:0] act_duty_r;
  logic [CHANNELS*WIDTH-1:0] sh_duty_r;
  logic [CHANNELS-1:0]       pwm_out_r;
  logic                      period_start_r;
  logic                      update_pending_r;

  logic                      boundary_s;
  logic                      load_s;
  logic [WIDTH-1:0]          eff_period_s;
  logic                      eff_center_s;
  logic [CHANNELS*WIDTH-1:0] eff_duty_s;
  logic                      running_s;
  logic [WIDTH-1:0]          cnt_next_s;
  logic                      dir_next_s;
  logic [CHANNELS-1:0]       pwm_next_s;
  logic                      pending_next_s;

  // Down-phase uses <= so a center-aligned pulse is exactly 2*D cycles wide.
  function automatic logic chan_hit(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] duty,
                                    input logic [WIDTH-1:0] per, input logic down);
    logic hit;
    if (duty >= per) begin
      hit = 1'b1;
    end else if (down) begin
      hit = (cnt <= duty);
    end else begin
      hit = (cnt < duty);
    end
    return hit;
  endfunction

  // Boundary selects the pre-edge shadow so the cnt==0 sample already uses the new values.
  always_comb begin
    boundary_s   = enable && (cnt_r == ZERO);
    load_s       = !enable || boundary_s;
    eff_period_s = boundary_s ? sh_period_r : act_period_r;
    eff_center_s = boundary_s ? sh_center_r : act_center_r;
    eff_duty_s   = boundary_s ? sh_duty_r : act_duty_r;
    running_s    = enable && (eff_period_s != ZERO);
  end

  // Counter next state: edge 0..P-1; center 0..P then P-1..1.
  always_comb begin
    cnt_next_s = cnt_r;
    dir_next_s = dir_down_r;
    if (!running_s) begin
      cnt_next_s = ZERO;
      dir_next_s = 1'b0;
    end else if (!eff_center_s) begin
      cnt_next_s = (cnt_r >= eff_period_s - ONE) ? ZERO : cnt_r + ONE;
      dir_next_s = 1'b0;
    end else if (!dir_down_r) begin
      if (cnt_r < eff_period_s) begin
        cnt_next_s = cnt_r + ONE;
        dir_next_s = 1'b0;
      end else if (eff_period_s == ONE) begin
        cnt_next_s = ZERO;
        dir_next_s = 1'b0;
      end else begin
        cnt_next_s = eff_period_s - ONE;
        dir_next_s = 1'b1;
      end
    end else begin
      if (cnt_r <= ONE) begin
        cnt_next_s = ZERO;
        dir_next_s = 1'b0;
      end else begin
        cnt_next_s = cnt_r - ONE;
        dir_next_s = 1'b1;
      end
    end
  end

  // Output compare and pending-flag next state.
  always_comb begin
    pwm_next_s = polarity;
    for (int i = 0; i < CHANNELS; i++) begin
      if (running_s) begin
        pwm_next_s[i] = chan_hit(cnt_r, eff_duty_s[i*WIDTH +: WIDTH], eff_period_s, dir_down_r)
                        ^ polarity[i];
      end else begin
        pwm_next_s[i] = polarity[i];
      end
    end
    if (!enable) begin
      pending_next_s = 1'b0;
    end else if (period_we || (|duty_we)) begin
      pending_next_s = 1'b1;
    end else if (boundary_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = update_pending_r;
    end
  end

  // State, shadow and active registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r            <= ZERO;
      dir_down_r       <= 1'b0;
      act_period_r     <= ZERO;
      sh_period_r      <= ZERO;
      act_center_r     <= 1'b0;
      sh_center_r      <= 1'b0;
      act_duty_r       <= {(CHANNELS*WIDTH){1'b0}};
      sh_duty_r        <= {(CHANNELS*WIDTH){1'b0}};
      pwm_out_r        <= {CHANNELS{1'b0}};
      period_start_r   <= 1'b0;
      update_pending_r <= 1'b0;
    end else begin
      cnt_r            <= cnt_next_s;
      dir_down_r       <= dir_next_s;
      pwm_out_r        <= pwm_next_s;
      period_start_r   <= boundary_s && running_s;
      update_pending_r <= pending_next_s;
      if (load_s) begin
        act_period_r <= sh_period_r;
        act_center_r <= sh_center_r;
        act_duty_r   <= sh_duty_r;
      end
      if (period_we) begin
        sh_period_r <= period_in;
        sh_center_r <= center_mode;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_we[i]) begin
          sh_duty_r[i*WIDTH +: WIDTH] <= duty_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign pwm_out        = pwm_out_r;
  assign period_start   = period_start_r;
  assign update_pending = update_pending_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (WIDTH=16, CHANNELS=4).
module tb_pwm_multi_channel;
  localparam int W = 16;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           center_mode;
  logic [W-1:0]   period_in;
  logic           period_we;
  logic [C*W-1:0] duty_in;
  logic [C-1:0]   duty_we;
  logic [C-1:0]   polarity;
  logic [C-1:0]   pwm_out;
  logic           period_start;
  logic           update_pending;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .enable(enable), .center_mode(center_mode),
    .period_in(period_in), .period_we(period_we), .duty_in(duty_in), .duty_we(duty_we),
    .polarity(polarity), .pwm_out(pwm_out), .period_start(period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; center_mode = 1'b0; period_in = 16'd0; period_we = 1'b0;
    duty_in = 64'd0; duty_we = 4'd0; polarity = 4'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic setup(input logic [15:0] p, input logic cm, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    period_in = p; center_mode = cm; period_we = 1'b1;
    duty_in = {d3, d2, d1, d0}; duty_we = 4'hF;
    tick();
    period_we = 1'b0; duty_we = 4'h0;
  endtask

  initial begin
    int j;
    logic [3:0] e;

    // Reset state
    do_reset();
    check("rst_pwm", pwm_out, 4'b0000);
    check("rst_ps", period_start, 1'b0);
    check("rst_pend", update_pending, 1'b0);

    // 1: edge mode P=10, D={12,10,0,3}
    setup(16'd10, 1'b0, 16'd3, 16'd0, 16'd10, 16'd12);
    check("t1_pend_idle", update_pending, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      j = (k - 1) % 10;
      e = {1'b1, 1'b1, 1'b0, (j < 3)};
      check("t1_pwm", pwm_out, e);
      check("t1_ps", period_start, (j == 0));
    end

    // 2: center mode P=8, D0=2 -> period 16, 4 high cycles around period_start
    do_reset();
    setup(16'd8, 1'b1, 16'd2, 16'd0, 16'd0, 16'd0);
    enable = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      j = (k - 1) % 16;
      e = {3'b000, ((j < 2) || (j >= 14))};
      check("t2_pwm", pwm_out, e);
      check("t2_ps", period_start, (j == 0));
    end

    // 3: D0 3 -> 7 written at cnt==4
    do_reset();
    setup(16'd10, 1'b0, 16'd3, 16'd0, 16'd0, 16'd0);
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        duty_in[15:0] = 16'd7; duty_we = 4'b0001;
      end
      tick();
      duty_we = 4'b0000;
      if (k <= 10) begin
        j = k - 1; e = {3'b000, (j < 3)};
      end else begin
        j = k - 11; e = {3'b000, (j < 7)};
      end
      check("t3_pwm", pwm_out, e);
      check("t3_pend", update_pending, ((k >= 5) && (k <= 10)));
      check("t3_ps", period_start, (j == 0));
    end

    // 4: P=20 written on the boundary edge takes effect one period later
    do_reset();
    setup(16'd10, 1'b0, 16'd5, 16'd0, 16'd0, 16'd0);
    enable = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 11) begin
        period_in = 16'd20; period_we = 1'b1;
      end
      tick();
      period_we = 1'b0;
      j = (k < 21) ? ((k - 1) % 10) : ((k - 21) % 20);
      check("t4_ps", period_start, ((k == 1) || (k == 11) || (k == 21) || (k == 41)));
      check("t4_pend", update_pending, ((k >= 11) && (k <= 20)));
      check("t4_pwm", pwm_out, {3'b000, (j < 5)});
    end

    // 5: polarity while idle, P==0 while enabled, recovery by a write
    do_reset();
    polarity = 4'b0101;
    tick();
    check("t5_idle_pwm", pwm_out, 4'b0101);
    check("t5_idle_ps", period_start, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t5_p0_pwm", pwm_out, 4'b0101);
      check("t5_p0_ps", period_start, 1'b0);
    end
    period_in = 16'd4; period_we = 1'b1; duty_in[15:0] = 16'd2; duty_we = 4'b0001;
    tick();
    period_we = 1'b0; duty_we = 4'b0000;
    check("t5_wr_pwm", pwm_out, 4'b0101);
    check("t5_wr_ps", period_start, 1'b0);
    check("t5_wr_pend", update_pending, 1'b1);
    tick();
    check("t5_rec_pwm", pwm_out, 4'b0100);
    check("t5_rec_ps", period_start, 1'b1);
    check("t5_rec_pend", update_pending, 1'b0);
    tick();
    check("t5_cnt1_pwm", pwm_out, 4'b0100);
    tick();
    check("t5_cnt2_pwm", pwm_out, 4'b0101);

    // 6: rst mid-period in center mode
    do_reset();
    setup(16'd8, 1'b1, 16'd2, 16'd0, 16'd0, 16'd0);
    enable = 1'b1;
    tick(); tick(); tick();
    duty_in[15:0] = 16'd3; duty_we = 4'b0001;
    tick();
    duty_we = 4'b0000;
    check("t6_pend_before", update_pending, 1'b1);
    tick(); tick();
    polarity = 4'b1000; rst = 1'b1;
    tick();
    check("t6_rst_pwm", pwm_out, 4'b0000);
    check("t6_rst_ps", period_start, 1'b0);
    check("t6_rst_pend", update_pending, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t6_p0_pwm", pwm_out, 4'b1000);
      check("t6_p0_ps", period_start, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
